// File: rtl/pll_sup_pkg.sv
// -----------------------------------------------------------------------------
// pll_sup_pkg
// Shared definitions for the PLL lock supervisor:
//   - state_e : supervisor FSM states; the encodings are visible to software
//               through state_o, so they must not be renumbered.
//   - STATE_W : width of the state encoding.
//   - cnt_width() : sizes the shared phase counter so that it can reach the
//               largest of the three phase lengths.
// -----------------------------------------------------------------------------
package pll_sup_pkg;

   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      ST_ASSERT_RST = 3'd0,
      ST_WAIT_LOCK  = 3'd1,
      ST_STABLE     = 3'd2,
      ST_RUN        = 3'd3,
      ST_FAIL       = 3'd4
   } state_e;

   // Bits needed for a counter whose terminal value is max(a,b,c)-1.
   function automatic int cnt_width(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return (m > 1) ? $clog2(m) : 1;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for a single asynchronous level signal.
// Ports:
//   clk     in  destination clock
//   reset_n in  asynchronous active-low reset, clears both flops to 0
//   d_i     in  asynchronous input
//   q_o     out synchronized output (two clk edges of latency)
// -----------------------------------------------------------------------------
module sync_2ff (
   input  logic clk,
   input  logic reset_n,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// -----------------------------------------------------------------------------
// pll_lock_supervisor
// Sequences the fabric PLL reset and the downstream system reset. Runs on the
// PLL reference clock so it never depends on a PLL output clock.
//
// Sequence: hold pll_rst for PLL_RST_CYCLES, wait up to LOCK_TIMEOUT for lock
// (retrying up to MAX_RETRIES times, then FAIL), require STABLE_CYCLES of
// continuous lock, then release sys_reset_n. Loss of lock in RUN or a
// relock_req restarts the sequence.
//
// Ports:
//   clk          in   reference clock (PLL refclk net)
//   reset_n      in   asynchronous active-low reset
//   pll_locked   in   PLL lock indicator, asynchronous to clk
//   relock_req   in   single-cycle request to restart the sequence
//   pll_rst      out  active-high PLL reset
//   sys_reset_n  out  active-low reset for consumers of the PLL clocks
//   fail         out  retries exhausted
//   lock_lost    out  one-cycle pulse when lock drops while in RUN
//   retry_cnt    out  retries used in the current sequence
//   loss_cnt     out  saturating count of lock_lost pulses (optional)
//   state_o      out  current state encoding for CSR readback
//
// Optional feature macro: PLL_LOCK_LOSS_COUNTER_EN adds loss_cnt[15:0].
// -----------------------------------------------------------------------------
module pll_lock_supervisor
   import pll_sup_pkg::*;
#(
   parameter int PLL_RST_CYCLES = 16,
   parameter int LOCK_TIMEOUT   = 50000,
   parameter int STABLE_CYCLES  = 1024,
   parameter int MAX_RETRIES    = 7
) (
   input  logic                               clk,
   input  logic                               reset_n,
   input  logic                               pll_locked,
   input  logic                               relock_req,
   output logic                               pll_rst,
   output logic                               sys_reset_n,
   output logic                               fail,
   output logic                               lock_lost,
   output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_cnt,
`ifdef PLL_LOCK_LOSS_COUNTER_EN
   output logic [15:0]                        loss_cnt,
`endif
   output logic [STATE_W-1:0]                 state_o
);

   localparam int CNT_W   = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
   localparam int RETRY_W = $clog2(MAX_RETRIES+1);

   localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0]   TO_LAST     = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0]   STB_LAST    = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRIES);

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [RETRY_W-1:0]   retry_q, retry_d;
   logic                 pll_rst_q, pll_rst_d;
   logic                 sys_rst_n_q, sys_rst_n_d;
   logic                 fail_q, fail_d;
   logic                 lock_lost_q, lock_lost_d;
   logic                 hold_sys;
   logic                 locked_s;

   sync_2ff u_lock_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d_i     (pll_locked),
      .q_o     (locked_s)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q + CNT_W'(1);
      retry_d     = retry_q;
      lock_lost_d = 1'b0;
      hold_sys    = 1'b0;

      if (relock_req) begin
         state_d = ST_ASSERT_RST;
         retry_d = '0;
      end else begin
         case (state_q)
            ST_ASSERT_RST: begin
               if (cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
               // A lock seen on the timeout cycle still counts as a lock.
               if (locked_s) begin
                  state_d = ST_STABLE;
               end else if (cnt_q == TO_LAST) begin
                  if (retry_q == RETRY_LIMIT) begin
                     state_d = ST_FAIL;
                  end else begin
                     retry_d = retry_q + RETRY_W'(1);
                     state_d = ST_ASSERT_RST;
                  end
               end
            end
            ST_STABLE: begin
               if (!locked_s)                state_d = ST_WAIT_LOCK;
               else if (cnt_q == STB_LAST)   state_d = ST_RUN;
            end
            ST_RUN: begin
               // sys_reset_n stays high for the lock_lost cycle so consumers
               // see the pulse before their reset asserts on the next edge.
               if (!locked_s) begin
                  state_d     = ST_ASSERT_RST;
                  retry_d     = '0;
                  lock_lost_d = 1'b1;
                  hold_sys    = 1'b1;
               end
            end
            ST_FAIL: begin
               state_d = ST_FAIL;
            end
            default: begin
               state_d = ST_ASSERT_RST;
            end
         endcase
      end

      // Counter restarts on every state change and on relock (which also
      // restarts the hold count when already in ASSERT_RST); it idles at 0
      // in the states that do not time anything.
      if (relock_req || (state_d != state_q) ||
          (state_d == ST_RUN) || (state_d == ST_FAIL)) begin
         cnt_d = '0;
      end

      pll_rst_d   = (state_d == ST_ASSERT_RST) || (state_d == ST_FAIL);
      sys_rst_n_d = (state_d == ST_RUN) || hold_sys;
      fail_d      = (state_d == ST_FAIL);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_ASSERT_RST;
         cnt_q       <= '0;
         retry_q     <= '0;
         pll_rst_q   <= 1'b1;
         sys_rst_n_q <= 1'b0;
         fail_q      <= 1'b0;
         lock_lost_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         retry_q     <= retry_d;
         pll_rst_q   <= pll_rst_d;
         sys_rst_n_q <= sys_rst_n_d;
         fail_q      <= fail_d;
         lock_lost_q <= lock_lost_d;
      end
   end

   assign pll_rst     = pll_rst_q;
   assign sys_reset_n = sys_rst_n_q;
   assign fail        = fail_q;
   assign lock_lost   = lock_lost_q;
   assign retry_cnt   = retry_q;
   assign state_o     = state_q;

`ifdef PLL_LOCK_LOSS_COUNTER_EN
   logic [15:0] loss_cnt_q;

   // Cleared only by reset_n; relock_req deliberately leaves it alone.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         loss_cnt_q <= '0;
      end else if (lock_lost_d && (loss_cnt_q != 16'hFFFF)) begin
         loss_cnt_q <= loss_cnt_q + 16'd1;
      end
   end

   assign loss_cnt = loss_cnt_q;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// -----------------------------------------------------------------------------
// tb_pll_lock_supervisor
// Directed bench for pll_lock_supervisor with PLL_RST_CYCLES=4,
// LOCK_TIMEOUT=32, STABLE_CYCLES=8, MAX_RETRIES=2. Comments below number the
// clock edges counted from the first edge after reset_n is released.
// -----------------------------------------------------------------------------
module tb_pll_lock_supervisor;

   logic       clk;
   logic       reset_n;
   logic       pll_locked;
   logic       relock_req;
   logic       pll_rst;
   logic       sys_reset_n;
   logic       fail;
   logic       lock_lost;
   logic [1:0] retry_cnt;
   logic [2:0] state_o;
`ifdef PLL_LOCK_LOSS_COUNTER_EN
   logic [15:0] loss_cnt;
`endif

   int n_vec = 0;
   int n_err = 0;
   int ll_seen = 0;

   pll_lock_supervisor #(
      .PLL_RST_CYCLES (4),
      .LOCK_TIMEOUT   (32),
      .STABLE_CYCLES  (8),
      .MAX_RETRIES    (2)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .pll_locked  (pll_locked),
      .relock_req  (relock_req),
      .pll_rst     (pll_rst),
      .sys_reset_n (sys_reset_n),
      .fail        (fail),
      .lock_lost   (lock_lost),
      .retry_cnt   (retry_cnt),
`ifdef PLL_LOCK_LOSS_COUNTER_EN
      .loss_cnt    (loss_cnt),
`endif
      .state_o     (state_o)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Advance n edges; sample 1 ns after each edge and note any lock_lost pulse.
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         if (lock_lost === 1'b1) ll_seen++;
      end
   endtask

   task automatic wait_state(input logic [2:0] s, input int lim, input string tag);
      int k;
      k = 0;
      while (state_o !== s && k < lim) begin
         tick(1);
         k++;
      end
      chk(tag, {29'd0, state_o}, {29'd0, s});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n    = 1'b0;
      pll_locked = 1'b0;
      relock_req = 1'b0;
      tick(2);
      chk("rst_state",   state_o,     3'd0);
      chk("rst_pll_rst", pll_rst,     1'b1);
      chk("rst_sys",     sys_reset_n, 1'b0);
      chk("rst_fail",    fail,        1'b0);
      chk("rst_ll",      lock_lost,   1'b0);
      chk("rst_retry",   retry_cnt,   2'd0);
      reset_n = 1'b1;

      // Nominal: pll_rst high for edges 1..3, falls at edge 4.
      for (int i = 1; i <= 3; i++) begin
         tick(1);
         chk("nom_pll_rst_hi", pll_rst, 1'b1);
      end
      tick(1);
      chk("nom_pll_rst_lo", pll_rst, 1'b0);
      chk("nom_wait",       state_o, 3'd1);
      tick(10);                                   // edge 14
      pll_locked = 1'b1;                          // first sampled at edge 15
      tick(2);                                    // edge 16
      chk("nom_still_wait", state_o, 3'd1);
      tick(1);                                    // edge 17
      chk("nom_stable",     state_o, 3'd2);
      tick(7);                                    // edge 24
      chk("nom_sys_lo",     sys_reset_n, 1'b0);
      tick(1);                                    // edge 25 = 15 + 10
      chk("nom_sys_hi",     sys_reset_n, 1'b1);
      chk("nom_run",        state_o, 3'd3);
      chk("nom_retry",      retry_cnt, 2'd0);

      // Loss in RUN: locked_s falls after edge 27.
      pll_locked = 1'b0;
      tick(2);                                    // edge 27
      chk("loss_pre_ll",  lock_lost,   1'b0);
      chk("loss_pre_sys", sys_reset_n, 1'b1);
      tick(1);                                    // edge 28
      chk("loss_ll",      lock_lost,   1'b1);
      chk("loss_state",   state_o,     3'd0);
      chk("loss_sys_hold", sys_reset_n, 1'b1);
      chk("loss_pll_rst", pll_rst,     1'b1);
      tick(1);                                    // edge 29
      chk("loss_ll_off",  lock_lost,   1'b0);
      chk("loss_sys_lo",  sys_reset_n, 1'b0);
      tick(2);                                    // edge 31
      chk("loss_pll_rst4", pll_rst,    1'b1);
      tick(1);                                    // edge 32
      chk("loss_pll_fall", pll_rst,    1'b0);
      chk("loss_retry",   retry_cnt,   2'd0);

      // Glitch in STABLE: sampled high 33..37, low 38, high from 39.
      pll_locked = 1'b1;
      tick(3);                                    // edge 35
      chk("gl_stable",    state_o, 3'd2);
      tick(2);                                    // edge 37
      pll_locked = 1'b0;
      tick(1);                                    // edge 38
      pll_locked = 1'b1;
      tick(1);                                    // edge 39
      chk("gl_still_stb", state_o, 3'd2);
      tick(1);                                    // edge 40
      chk("gl_back_wait", state_o, 3'd1);
      chk("gl_retry",     retry_cnt, 2'd0);
      tick(1);                                    // edge 41
      chk("gl_restable",  state_o, 3'd2);
      tick(7);                                    // edge 48
      chk("gl_sys_lo",    sys_reset_n, 1'b0);
      tick(1);                                    // edge 49
      chk("gl_sys_hi",    sys_reset_n, 1'b1);

      // relock_req coincides with the lock drop being seen (edge 52).
      pll_locked = 1'b0;
      tick(2);                                    // edge 51
      ll_seen = 0;
      relock_req = 1'b1;
      tick(1);                                    // edge 52
      relock_req = 1'b0;
      chk("rl_state",   state_o,     3'd0);
      chk("rl_sys",     sys_reset_n, 1'b0);
      chk("rl_pll_rst", pll_rst,     1'b1);
      tick(1);                                    // edge 53
      chk("rl_no_ll",   ll_seen,     0);

      // Timeouts with lock held low: WAIT_LOCK entered at edge 56.
      tick(34);                                   // edge 87
      chk("to1_wait",    state_o,   3'd1);
      chk("to1_retry0",  retry_cnt, 2'd0);
      tick(1);                                    // edge 88
      chk("to1_assert",  state_o,   3'd0);
      chk("to1_retry1",  retry_cnt, 2'd1);
      tick(3);                                    // edge 91
      chk("to1_pll_rst", pll_rst,   1'b1);
      tick(1);                                    // edge 92
      chk("to1_pll_lo",  pll_rst,   1'b0);
      tick(32);                                   // edge 124
      chk("to2_assert",  state_o,   3'd0);
      chk("to2_retry2",  retry_cnt, 2'd2);
      tick(35);                                   // edge 159
      chk("to3_wait",    state_o,   3'd1);
      chk("to3_nofail",  fail,      1'b0);
      tick(1);                                    // edge 160
      chk("fail_state",  state_o,   3'd4);
      chk("fail_flag",   fail,      1'b1);
      chk("fail_pll",    pll_rst,   1'b1);
      chk("fail_sys",    sys_reset_n, 1'b0);
      tick(2);                                    // edge 162
      chk("fail_held",   state_o,   3'd4);

      // Recovery from FAIL with lock held high.
      pll_locked = 1'b1;
      ll_seen = 0;
      relock_req = 1'b1;
      tick(1);                                    // edge 163
      relock_req = 1'b0;
      chk("rec_fail_clr", fail,      1'b0);
      chk("rec_state",    state_o,   3'd0);
      chk("rec_retry",    retry_cnt, 2'd0);
      tick(4);                                    // edge 167
      chk("rec_wait",     state_o,   3'd1);
      tick(1);                                    // edge 168
      chk("rec_stable",   state_o,   3'd2);
      tick(7);                                    // edge 175
      chk("rec_sys_lo",   sys_reset_n, 1'b0);
      tick(1);                                    // edge 176
      chk("rec_sys_hi",   sys_reset_n, 1'b1);
      chk("rec_no_ll",    ll_seen,   0);

`ifdef PLL_LOCK_LOSS_COUNTER_EN
      chk("lc_one", loss_cnt, 16'd1);
      for (int i = 0; i < 2; i++) begin
         pll_locked = 1'b0;
         wait_state(3'd0, 10, "lc_drop");
         pll_locked = 1'b1;
         wait_state(3'd3, 40, "lc_rerun");
      end
      chk("lc_three", loss_cnt, 16'd3);
      relock_req = 1'b1;
      tick(1);
      relock_req = 1'b0;
      wait_state(3'd3, 40, "lc_relock_run");
      chk("lc_relock_keep", loss_cnt, 16'd3);
`endif

      // Asynchronous reset in the middle of a RUN cycle.
      @(posedge clk);
      #5;
      reset_n = 1'b0;
      #1;
      chk("ar_sys",     sys_reset_n, 1'b0);
      chk("ar_pll_rst", pll_rst,     1'b1);
      chk("ar_state",   state_o,     3'd0);
`ifdef PLL_LOCK_LOSS_COUNTER_EN
      chk("ar_loss_cnt", loss_cnt, 16'd0);
`endif
      tick(2);
      chk("ar_hold_sys", sys_reset_n, 1'b0);
      reset_n = 1'b1;
      tick(1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
